// File: rtl/exec_ctrl.sv
// exec_ctrl: run / halt / single-step execution controller with an optional
// instruction-address breakpoint and a saturating executed-cycle counter.
//
// Configuration macro: EXEC_CTRL_BP_EN
//   defined   -> breakpoint logic, the BREAK state and bp_hit are built in.
//   undefined -> bp_en/bp_addr are ignored, bp_hit is tied 0, and RUN stops
//                only on a halt edge.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous active-low reset
//   run        in   level button; a rising edge requests free-run
//   halt       in   level button; a rising edge requests stop
//   step       in   level button; a rising edge requests one instruction
//   clr_cnt    in   synchronous clear of cycle_cnt
//   ip         in   current program-counter value
//   bp_en      in   breakpoint enable
//   bp_addr    in   breakpoint instruction address
//   cpu_en     out  datapath enable (combinational)
//   state      out  HALT=00 RUN=01 STEP=10 BREAK=11 (registered)
//   bp_hit     out  high while in BREAK (registered)
//   cycle_cnt  out  count of cycles with cpu_en=1, saturating (registered)
module exec_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             halt,
    input  logic             step,
    input  logic             clr_cnt,
    input  logic [4:0]       ip,
    input  logic             bp_en,
    input  logic [4:0]       bp_addr,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t cur_state;
    state_t next_state;

    logic run_q;
    logic halt_q;
    logic step_q;
    logic run_edge;
    logic halt_edge;
    logic step_edge;
    logic bp_match;

    assign state = cur_state;

    // Rising-edge detection against the previous-cycle button levels
    assign run_edge  = run  & ~run_q;
    assign halt_edge = halt & ~halt_q;
    assign step_edge = step & ~step_q;

`ifdef EXEC_CTRL_BP_EN
    logic skip;

    // skip lets a resume from bp_addr execute that instruction once
    assign bp_match = bp_en && (ip == bp_addr) && !skip;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skip   <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            bp_hit <= (next_state == ST_BREAK);
            if (next_state == ST_RUN && cur_state != ST_RUN) begin
                skip <= 1'b1;
            end else if (cur_state == ST_RUN && cpu_en) begin
                skip <= 1'b0;
            end
        end
    end
`else
    logic unused_bp;

    assign unused_bp = ^{ip, bp_en, bp_addr};
    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    // Next-state and datapath enable; halt > step > run, others dropped
    always_comb begin
        next_state = cur_state;
        cpu_en     = 1'b0;
        case (cur_state)
            ST_HALT, ST_BREAK: begin
                if (halt_edge) begin
                    next_state = ST_HALT;
                end else if (step_edge) begin
                    next_state = ST_STEP;
                end else if (run_edge) begin
                    next_state = ST_RUN;
                end
            end
            ST_STEP: begin
                cpu_en     = 1'b1;
                next_state = ST_HALT;
            end
            ST_RUN: begin
                if (halt_edge) begin
                    next_state = ST_HALT;
                end else if (bp_match) begin
                    next_state = ST_BREAK;
                end else begin
                    cpu_en = 1'b1;
                end
            end
            default: next_state = ST_HALT;
        endcase
        // A cycle under reset never executes
        if (!rst_n) begin
            cpu_en = 1'b0;
        end
    end

    // State, edge-detect history and cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= ST_HALT;
            run_q     <= 1'b1;
            halt_q    <= 1'b1;
            step_q    <= 1'b1;
            cycle_cnt <= '0;
        end else begin
            cur_state <= next_state;
            run_q     <= run;
            halt_q    <= halt;
            step_q    <= step;
            if (clr_cnt) begin
                cycle_cnt <= '0;
            end else if (cpu_en && cycle_cnt != {CNT_W{1'b1}}) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed bench for exec_ctrl (CNT_W=8) with a 5-bit pc
// model that advances whenever cpu_en is high.
module tb_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       halt;
    logic       step;
    logic       clr_cnt;
    logic [4:0] ip;
    logic       bp_en;
    logic [4:0] bp_addr;
    logic       cpu_en;
    logic [1:0] state;
    logic       bp_hit;
    logic [7:0] cycle_cnt;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] S_HALT  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_STEP  = 2'b10;
    localparam logic [1:0] S_BREAK = 2'b11;

    exec_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt(halt), .step(step),
        .clr_cnt(clr_cnt), .ip(ip), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Program counter model
    always @(posedge clk) begin
        if (!rst_n) ip <= 5'd0;
        else if (cpu_en) ip <= ip + 5'd1;
    end

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; halt = 1'b0; step = 1'b0;
        clr_cnt = 1'b0; bp_en = 1'b0; bp_addr = 5'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic halt_pulse();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; halt = 1'b0; step = 1'b0;
        clr_cnt = 1'b0; bp_en = 1'b0; bp_addr = 5'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (state !== S_HALT) begin n_err++; $display("FAIL reset_state got %0d want %0d", state, S_HALT); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL reset_cpu_en got %b want 0", cpu_en); end
        n_cmp++; if (bp_hit !== 1'b0) begin n_err++; $display("FAIL reset_bp_hit got %b want 0", bp_hit); end
        n_cmp++; if (cycle_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", cycle_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== S_HALT) begin n_err++; $display("FAIL reset_release_state got %0d want %0d", state, S_HALT); end
    endtask

    task automatic test_step();
        do_reset();
        step = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== S_STEP) begin n_err++; $display("FAIL step_state got %0d want %0d", state, S_STEP); end
        n_cmp++; if (cpu_en !== 1'b1) begin n_err++; $display("FAIL step_cpu_en got %b want 1", cpu_en); end
        @(negedge clk);
        n_cmp++; if (state !== S_HALT) begin n_err++; $display("FAIL step_after_state got %0d want %0d", state, S_HALT); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL step_after_cpu_en got %b want 0", cpu_en); end
        n_cmp++; if (cycle_cnt !== 8'd1) begin n_err++; $display("FAIL step_cnt got %0d want 1", cycle_cnt); end
        n_cmp++; if (ip !== 5'd1) begin n_err++; $display("FAIL step_ip got %0d want 1", ip); end
        step = 1'b0;
        @(negedge clk);
        // step and run together: step wins, run edge discarded
        step = 1'b1; run = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== S_STEP) begin n_err++; $display("FAIL step_run_prio got %0d want %0d", state, S_STEP); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (state !== S_HALT) begin n_err++; $display("FAIL step_run_dropped got %0d want %0d", state, S_HALT); end
        n_cmp++; if (cycle_cnt !== 8'd2) begin n_err++; $display("FAIL step_run_cnt got %0d want 2", cycle_cnt); end
        step = 1'b0; run = 1'b0;
        @(negedge clk);
        // run edge arriving during STEP is discarded
        step = 1'b1;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (state !== S_HALT) begin n_err++; $display("FAIL step_edge_discard got %0d want %0d", state, S_HALT); end
        step = 1'b0; run = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_run_halt_same();
        do_reset();
        run = 1'b1; halt = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== S_HALT) begin n_err++; $display("FAIL same_edge_state got %0d want %0d", state, S_HALT); end
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL same_edge_cpu_en got %b want 0", cpu_en); end
        @(negedge clk);
        n_cmp++; if (state !== S_HALT) begin n_err++; $display("FAIL same_edge_hold got %0d want %0d", state, S_HALT); end
        run = 1'b0; halt = 1'b0;
        @(negedge clk);
    endtask

`ifdef EXEC_CTRL_BP_EN
    task automatic test_breakpoint();
        do_reset();
        bp_en = 1'b1; bp_addr = 5'd5; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (cpu_en !== 1'b1 || ip !== 5'(i)) begin n_err++; $display("FAIL bp_run_%0d got cpu_en=%b ip=%0d want 1 ip=%0d", i, cpu_en, ip, i); end
            @(negedge clk);
        end
        n_cmp++; if (cpu_en !== 1'b0 || state !== S_RUN) begin n_err++; $display("FAIL bp_match got cpu_en=%b state=%0d want 0/%0d", cpu_en, state, S_RUN); end
        @(negedge clk);
        n_cmp++; if (state !== S_BREAK) begin n_err++; $display("FAIL bp_state got %0d want %0d", state, S_BREAK); end
        n_cmp++; if (bp_hit !== 1'b1) begin n_err++; $display("FAIL bp_hit got %b want 1", bp_hit); end
        n_cmp++; if (cycle_cnt !== 8'd5) begin n_err++; $display("FAIL bp_cnt got %0d want 5", cycle_cnt); end
        n_cmp++; if (ip !== 5'd5 || cpu_en !== 1'b0) begin n_err++; $display("FAIL bp_hold got ip=%0d cpu_en=%b want 5/0", ip, cpu_en); end
        // resume: instruction at bp_addr executes once
        run = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== S_RUN || cpu_en !== 1'b1 || ip !== 5'd5) begin n_err++; $display("FAIL bp_resume got state=%0d cpu_en=%b ip=%0d want 1/1/5", state, cpu_en, ip); end
        n_cmp++; if (bp_hit !== 1'b0) begin n_err++; $display("FAIL bp_hit_clear got %b want 0", bp_hit); end
        run = 1'b0;
        @(negedge clk);
        n_cmp++; if (ip !== 5'd6 || cpu_en !== 1'b1) begin n_err++; $display("FAIL bp_continue got ip=%0d cpu_en=%b want 6/1", ip, cpu_en); end
        halt = 1'b1;
        #1;
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL halt_gate got %b want 0", cpu_en); end
        @(negedge clk);
        n_cmp++; if (state !== S_HALT || ip !== 5'd6) begin n_err++; $display("FAIL halt_stop got state=%0d ip=%0d want 0/6", state, ip); end
        halt = 1'b0;
        // halt coincident with a breakpoint match goes to HALT
        bp_addr = 5'd8; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (ip !== 5'd8 || cpu_en !== 1'b0) begin n_err++; $display("FAIL bp8_match got ip=%0d cpu_en=%b want 8/0", ip, cpu_en); end
        halt = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== S_HALT || bp_hit !== 1'b0) begin n_err++; $display("FAIL halt_over_bp got state=%0d bp_hit=%b want 0/0", state, bp_hit); end
        halt = 1'b0;
        @(negedge clk);
    endtask
`else
    task automatic test_no_breakpoint();
        do_reset();
        bp_en = 1'b1; bp_addr = 5'd3; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 40; i++) begin
            n_cmp++; if (cpu_en !== 1'b1 || bp_hit !== 1'b0 || state !== S_RUN) begin n_err++; $display("FAIL nobp_run_%0d got cpu_en=%b bp_hit=%b state=%0d want 1/0/1", i, cpu_en, bp_hit, state); end
            @(negedge clk);
        end
        n_cmp++; if (ip !== 5'd8) begin n_err++; $display("FAIL nobp_wrap_ip got %0d want 8", ip); end
        halt_pulse();
        n_cmp++; if (state !== S_HALT) begin n_err++; $display("FAIL nobp_halt got %0d want 0", state); end
    endtask
`endif

    task automatic test_saturate();
        do_reset();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (300) @(negedge clk);
        n_cmp++; if (cycle_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cnt got %0d want 255", cycle_cnt); end
        n_cmp++; if (state !== S_RUN) begin n_err++; $display("FAIL sat_state got %0d want 1", state); end
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        n_cmp++; if (cycle_cnt !== 8'd0) begin n_err++; $display("FAIL clr_cnt got %0d want 0", cycle_cnt); end
        @(negedge clk);
        n_cmp++; if (cycle_cnt !== 8'd1) begin n_err++; $display("FAIL clr_then_inc got %0d want 1", cycle_cnt); end
        halt_pulse();
        n_cmp++; if (state !== S_HALT) begin n_err++; $display("FAIL sat_halt got %0d want 0", state); end
    endtask

    task automatic test_held_reset();
        rst_n = 1'b0; run = 1'b1; halt = 1'b0; step = 1'b0; clr_cnt = 1'b0; bp_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (state !== S_HALT || cpu_en !== 1'b0) begin n_err++; $display("FAIL held_run_%0d got state=%0d cpu_en=%b want 0/0", i, state, cpu_en); end
        end
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== S_RUN) begin n_err++; $display("FAIL held_repress got %0d want 1", state); end
        run = 1'b0;
        halt_pulse();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        n_cmp++; if (state !== S_RUN || cpu_en !== 1'b1) begin n_err++; $display("FAIL mid_run_pre got state=%0d cpu_en=%b want 1/1", state, cpu_en); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL mid_run_cpu_en got %b want 0", cpu_en); end
        @(negedge clk);
        n_cmp++; if (state !== S_HALT || cycle_cnt !== 8'd0) begin n_err++; $display("FAIL mid_run_state got state=%0d cnt=%0d want 0/0", state, cycle_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        n_cmp++; if (state !== S_STEP) begin n_err++; $display("FAIL mid_step_pre got %0d want 2", state); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL mid_step_cpu_en got %b want 0", cpu_en); end
        @(negedge clk);
        n_cmp++; if (state !== S_HALT) begin n_err++; $display("FAIL mid_step_state got %0d want 0", state); end
        step = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_halt_same();
`ifdef EXEC_CTRL_BP_EN
        test_breakpoint();
`else
        test_no_breakpoint();
`endif
        test_saturate();
        test_held_reset();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
